pipelined_barrel_shifter: RTL and testbench
===========================================

# pipelined_barrel_shifter

Parametrised, pipelined barrel shifter: a WIDTH-bit operand is shifted or rotated by a SHW-bit amount in one of five modes, with one logarithmic stage per pipeline register. Valid/ready handshakes on both sides allow full-throughput streaming with backpressure. It is the datapath shift unit for the ALU and any stream-processing block that needs variable shifts wider than 8 bits.

## Interface
- WIDTH, 32: operand width; power of two, minimum 4.
- SHW, $clog2(WIDTH): shift-amount width. Derived; never override.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts the input beat this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift amount, 0..WIDTH-1.
- in_mode  input  3  000 ROR, 001 ROL, 010 SRL, 011 SLL, 100 SRA, 101..111 pass-through.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  result.
- out_zero  output  1  result is all zeros; present only with the macro below.

## Operation
- Handshake on each side: a beat transfers on a rising clk with valid && ready both high.
- Pipeline of LAT = SHW stages. Stage k (k = 0..SHW-1, LSB first) applies a shift of 2^k when in_amt[k] = 1, otherwise passes its data through. in_amt and in_mode travel with the data.
- ROR: out = data rotated right by in_amt. ROL: rotated left by in_amt.
- SRL: logical right shift with zero fill. SLL: left shift with zero fill.
- SRA: right shift filled with in_data[WIDTH-1].
- Reserved modes: out = in_data unchanged.
- in_amt = 0 gives out = in_data for every mode.
- Stall: the whole pipeline freezes when out_valid = 1 and out_ready = 0. in_ready = rst_n && !(out_valid && !out_ready), which is combinational from out_ready.
- Each stage has its own valid bit. Bubbles propagate; they are not compressed.
- Frozen stages hold their data, amount, mode and valid bits exactly.
- in_data, in_amt and in_mode are don't-care when in_valid = 0. Data registers need not be cleared on bubbles.

## Timing
- Reset (rst_n = 0 at a rising edge): every stage valid bit = 0, out_valid = 0, out_data = 0, out_zero = 0 (when present).
- in_ready = 0 for as long as rst_n is low.
- Reset mid-operation discards all in-flight beats. No output is produced for them.
- Latency: a beat accepted at edge t has out_valid = 1 after edge t+LAT when there are no stalls. WIDTH = 8 gives 3 cycles. WIDTH = 32 gives 5 cycles.
- Throughput: one beat per cycle when out_ready is held high.
- Simultaneous accept and emit in the same cycle is legal and required.
- out_data and out_valid are registered outputs. They stay stable while out_valid = 1 and out_ready = 0.
- No combinational path from in_* to out_*.

## Configuration
- PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN defined:
  - Port out_zero exists.
  - out_zero is registered with out_data and equals (out_data == 0).
  - It obeys the same stall and reset rules as out_data.
- Macro undefined: port out_zero and its logic are absent. All other behaviour is identical.

## Test plan
- Modes, WIDTH = 8, in_data = 8'hB4, in_amt = 3, out_ready = 1: ROR -> 8'h96; ROL -> 8'hA5; SRL -> 8'h16; SLL -> 8'hA0; SRA -> 8'hF6; mode 3'b111 -> 8'hB4. Each result appears exactly 3 cycles after acceptance.
- Boundaries, WIDTH = 8: any mode with in_amt = 0 -> 8'hB4. SRA of 8'h80 by 7 -> 8'hFF. SRL of 8'h80 by 7 -> 8'h01. ROL of 8'h01 by 7 -> 8'h80. Random sweep of all data, amount and mode combinations checked against a reference model.
- Streaming and backpressure, WIDTH = 32: issue 20 back-to-back beats, then drop out_ready for 4 cycles mid-stream. Required: in_ready falls in the same cycle; out_data is held; no beat is lost or duplicated; order is preserved; with out_ready high, throughput is 1 beat per cycle.
- Bubbles: alternate in_valid 1/0. out_valid must show the same 1/0 pattern delayed by LAT cycles, with correct data.
- Reset mid-stream: assert rst_n = 0 for 1 cycle with 3 beats in flight. Required: out_valid = 0 and out_data = 0 after that edge; the in-flight beats never appear; a new beat returns after LAT cycles.
- Zero flag, macro defined, WIDTH = 8: SLL of 8'h80 by 1 -> out_data = 8'h00 with out_zero = 1. ROR of 8'h80 by 1 -> 8'h40 with out_zero = 0.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined log-stage barrel shifter (ROR/ROL/SRL/SLL/SRA), optional out_zero via PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam logic [2:0] MODE_ROR = 3'b000;
  localparam logic [2:0] MODE_ROL = 3'b001;
  localparam logic [2:0] MODE_SRL = 3'b010;
  localparam logic [2:0] MODE_SLL = 3'b011;
  localparam logic [2:0] MODE_SRA = 3'b100;

  // Whole pipeline freezes while a finished result waits for the consumer
  logic stall;

  // One fixed-distance step; composing log2 steps gives any amount. SRA keeps the
  // sign bit intact at every step, so the original MSB fills all vacated bits.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [2:0]       m,
                                                  input int               s);
    case (m)
      MODE_ROR: shift_step = (d >> s) | (d << (WIDTH - s));
      MODE_ROL: shift_step = (d << s) | (d >> (WIDTH - s));
      MODE_SRL: shift_step = d >> s;
      MODE_SLL: shift_step = d << s;
      MODE_SRA: shift_step = $signed(d) >>> s;
      default:  shift_step = d;
    endcase
  endfunction

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic [WIDTH-1:0] src_d;
    logic [WIDTH-1:0] nxt_d;
    logic [WIDTH-1:0] d_q;
    logic [2:0]       src_m;
    logic             src_v;
    logic             amt_bit;
    logic             v_q;

    if (k == 0) begin : g_src
      assign src_d   = in_data;
      assign src_m   = in_mode;
      assign src_v   = in_valid;
      assign amt_bit = in_amt[0];
    end else begin : g_src
      assign src_d   = g_stage[k-1].d_q;
      assign src_m   = g_stage[k-1].g_carry.m_q;
      assign src_v   = g_stage[k-1].v_q;
      assign amt_bit = g_stage[k-1].g_carry.a_q[k];
    end

    assign nxt_d = amt_bit ? shift_step(src_d, src_m, 2 ** k) : src_d;

    // Stage register: advance data and valid together unless the pipe is frozen
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (!stall) begin
        v_q <= src_v;
        d_q <= nxt_d;
      end
    end

    // Only the amount bits still to be applied travel on; the last stage needs none
    if (k < SHW - 1) begin : g_carry
      logic [SHW-1:k+1] a_src;
      logic [SHW-1:k+1] a_q;
      logic [2:0]       m_q;

      if (k == 0) begin : g_a
        assign a_src = in_amt[SHW-1:1];
      end else begin : g_a
        assign a_src = g_stage[k-1].g_carry.a_q[SHW-1:k+1];
      end

      // Amount and mode ride with the data; contents are don't-care on bubbles
      always_ff @(posedge clk) begin
        if (!stall) begin
          a_q <= a_src;
          m_q <= src_m;
        end
      end
    end
  end

  assign stall     = g_stage[SHW-1].v_q && !out_ready;
  assign in_ready  = rst_n && !stall;
  assign out_valid = g_stage[SHW-1].v_q;
  assign out_data  = g_stage[SHW-1].d_q;

`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag registered with the final stage so it always matches out_data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (!stall) begin
      zero_q <= (g_stage[SHW-1].nxt_d == '0);
    end
  end

  assign out_zero = zero_q;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - self-checking bench for pipelined_barrel_shifter (WIDTH 8 and 32)
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v8, r8, ov8, or8;
  logic [7:0]  d8, od8;
  logic [2:0]  a8, m8;
  logic        v32, r32, ov32, or32;
  logic [31:0] d32, od32;
  logic [4:0]  a32;
  logic [2:0]  m32;
`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
  logic        z8, z32;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] q8[$];
  logic [31:0] q32[$];
  logic        hold8 = 1'b0, hold32 = 1'b0;
  logic [7:0]  hold8_val;
  logic [31:0] hold32_val;

  pipelined_barrel_shifter #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(r8), .in_data(d8), .in_amt(a8), .in_mode(m8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8)
`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
    , .out_zero(z8)
`endif
  );

  pipelined_barrel_shifter #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v32), .in_ready(r32), .in_data(d32), .in_amt(a32), .in_mode(m32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32)
`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
    , .out_zero(z32)
`endif
  );

  // Bit-by-bit reference: each result bit is picked from its source position.
  function automatic logic [31:0] model(input int w, input logic [31:0] d,
                                        input int a, input logic [2:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        3'd0:    r[i] = d[(i + a) % w];
        3'd1:    r[i] = d[(i - a + w) % w];
        3'd2:    r[i] = (i + a < w) ? d[i + a] : 1'b0;
        3'd3:    r[i] = (i >= a) ? d[i - a] : 1'b0;
        3'd4:    r[i] = (i + a < w) ? d[i + a] : d[w - 1];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc8(input logic v, input logic [7:0] d, input logic [2:0] a,
                      input logic [2:0] m, input logic ordy, output logic acc, output logic em);
    logic [31:0] e;
    @(negedge clk);
    v8 = v; d8 = d; a8 = a; m8 = m; or8 = ordy;
    #1;
    if (hold8) begin
      check("hold_valid8", 32'(ov8), 32'd1);
      check("hold_data8", 32'(od8), 32'(hold8_val));
    end
    check("in_ready8", 32'(r8), 32'(!(ov8 && !ordy)));
    em = ov8 && ordy;
    if (em) begin
      if (q8.size() == 0) check("spurious8", 32'(ov8), 32'd0);
      else begin
        e = q8.pop_front();
        check("data8", 32'(od8), e);
`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
        check("zero8", 32'(z8), 32'(e == 32'd0));
`endif
      end
    end
    hold8 = ov8 && !ordy;
    hold8_val = od8;
    acc = v && r8;
    if (acc) q8.push_back(model(8, 32'(d), int'(a), m));
  endtask

  task automatic cyc32(input logic v, input logic [31:0] d, input logic [4:0] a,
                       input logic [2:0] m, input logic ordy, output logic acc, output logic em);
    logic [31:0] e;
    @(negedge clk);
    v32 = v; d32 = d; a32 = a; m32 = m; or32 = ordy;
    #1;
    if (hold32) begin
      check("hold_valid32", 32'(ov32), 32'd1);
      check("hold_data32", od32, hold32_val);
    end
    check("in_ready32", 32'(r32), 32'(!(ov32 && !ordy)));
    em = ov32 && ordy;
    if (em) begin
      if (q32.size() == 0) check("spurious32", 32'(ov32), 32'd0);
      else begin
        e = q32.pop_front();
        check("data32", od32, e);
`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
        check("zero32", 32'(z32), 32'(e == 32'd0));
`endif
      end
    end
    hold32 = ov32 && !ordy;
    hold32_val = od32;
    acc = v && r32;
    if (acc) q32.push_back(model(32, d, int'(a), m));
  endtask

  task automatic one8(input string tag, input logic [7:0] d, input logic [2:0] a,
                      input logic [2:0] m, input logic [7:0] exp);
    int lat;
    @(negedge clk);
    v8 = 1'b1; d8 = d; a8 = a; m8 = m; or8 = 1'b1;
    #1;
    check({tag, "_acc"}, 32'(r8), 32'd1);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      v8 = 1'b0;
      #1;
      if (ov8) lat = i;
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check(tag, 32'(od8), 32'(exp));
`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
    check({tag, "_zero"}, 32'(z8), 32'(exp == 8'h00));
`endif
  endtask

  logic [31:0] bd[20];
  logic [4:0]  ba[20];
  logic [2:0]  bm[20];
  logic        vh[20], oh[20];

  initial begin
    logic acc, em;
    int   bi, first, last, emits, ghosts, lat;

    rst_n = 1'b0;
    v8 = 0; d8 = 0; a8 = 0; m8 = 0; or8 = 1;
    v32 = 0; d32 = 0; a32 = 0; m32 = 0; or32 = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready8", 32'(r8), 32'd0);
    check("rst_valid8", 32'(ov8), 32'd0);
    check("rst_data8", 32'(od8), 32'd0);
    check("rst_ready32", 32'(r32), 32'd0);
    check("rst_valid32", 32'(ov32), 32'd0);
    check("rst_data32", od32, 32'd0);
`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
    check("rst_zero8", 32'(z8), 32'd0);
`endif
    rst_n = 1'b1;

    one8("ror", 8'hB4, 3'd3, 3'b000, 8'h96);
    one8("rol", 8'hB4, 3'd3, 3'b001, 8'hA5);
    one8("srl", 8'hB4, 3'd3, 3'b010, 8'h16);
    one8("sll", 8'hB4, 3'd3, 3'b011, 8'hA0);
    one8("sra", 8'hB4, 3'd3, 3'b100, 8'hF6);
    one8("pass", 8'hB4, 3'd3, 3'b111, 8'hB4);
    for (int mm = 0; mm < 8; mm++) one8("amt0", 8'hB4, 3'd0, 3'(mm), 8'hB4);
    one8("sra_80_7", 8'h80, 3'd7, 3'b100, 8'hFF);
    one8("srl_80_7", 8'h80, 3'd7, 3'b010, 8'h01);
    one8("rol_01_7", 8'h01, 3'd7, 3'b001, 8'h80);
    one8("zf_sll", 8'h80, 3'd1, 3'b011, 8'h00);
    one8("zf_ror", 8'h80, 3'd1, 3'b000, 8'h40);

    for (int c = 0; c < 300; c++)
      cyc8($urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom), 3'($urandom),
           $urandom_range(0, 3) != 0, acc, em);
    for (int c = 0; c < 40 && q8.size() > 0; c++) cyc8(1'b0, 8'h0, 3'd0, 3'd0, 1'b1, acc, em);
    check("sweep_drained8", 32'(q8.size()), 32'd0);

    for (int i = 0; i < 20; i++) begin
      bd[i] = $urandom; ba[i] = 5'($urandom); bm[i] = 3'($urandom_range(0, 4));
    end
    bi = 0; first = -1; last = -1; emits = 0;
    for (int c = 0; c < 100 && (bi < 20 || q32.size() > 0); c++) begin
      cyc32(bi < 20, bd[bi % 20], ba[bi % 20], bm[bi % 20], !(c >= 10 && c < 14), acc, em);
      if (c == 10) check("ready_drop", 32'(r32), 32'd0);
      if (acc) bi++;
      if (em) begin
        emits++;
        if (first < 0) first = c;
        last = c;
      end
    end
    check("stream_accepted", 32'(bi), 32'd20);
    check("stream_emits", 32'(emits), 32'd20);
    check("stream_drained", 32'(q32.size()), 32'd0);
    check("throughput_span", 32'(last - first + 1), 32'd24);

    for (int c = 0; c < 20; c++) begin
      cyc32(c < 12 && (c % 2 == 0), $urandom, 5'($urandom), 3'($urandom), 1'b1, acc, em);
      vh[c] = acc;
      oh[c] = em;
    end
    for (int c = 5; c < 20; c++) check("bubble_pattern", 32'(oh[c]), 32'(vh[c - 5]));

    for (int c = 0; c < 3; c++) cyc32(1'b1, $urandom, 5'($urandom), 3'd1, 1'b1, acc, em);
    @(negedge clk);
    v32 = 1'b0; rst_n = 1'b0;
    #1;
    check("ready_in_reset", 32'(r32), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_valid", 32'(ov32), 32'd0);
    check("midrst_data", od32, 32'd0);
    q32.delete();
    hold32 = 1'b0;
    ghosts = 0;
    for (int c = 0; c < 8; c++) begin
      cyc32(1'b0, 32'h0, 5'd0, 3'd0, 1'b1, acc, em);
      if (em) ghosts++;
    end
    check("ghost_beats", 32'(ghosts), 32'd0);
    cyc32(1'b1, 32'h8000_0001, 5'd4, 3'b100, 1'b1, acc, em);
    check("post_rst_accept", 32'(acc), 32'd1);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      cyc32(1'b0, 32'h0, 5'd0, 3'd0, 1'b1, acc, em);
      if (em) lat = i;
    end
    check("post_rst_latency", 32'(lat), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
